// File: rtl/instr_fetch_prefetch.sv
// instr_fetch_prefetch
// Sequential instruction fetch unit and sole read master of the on-chip instruction
// memory. Each issued word read is tagged with its PC and buffered in a small prefetch
// FIFO, which is presented to the core over a valid/ready stream. A redirect flushes
// the FIFO, drops any in-flight read and restarts fetching at the new PC.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   fetch_en            1 = fetching permitted (IDLE <-> RUN)
//   redirect_valid/_pc  one-cycle flush and restart request with the new word address
//   mem_*               read port to the instruction memory (fixed 1-cycle latency)
//   instr_valid/_ready  stream handshake at the FIFO head
//   instr_data/_pc      head instruction word and its word address (0 when empty)
//   idle                IDLE state, nothing in flight, FIFO empty
module instr_fetch_prefetch #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              idle
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_tag;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [31:0]         r_fifo_data [DEPTH];
  logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];

  logic [CNT_W-1:0]    w_credit;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_nonempty;

  // Credit counts the outstanding read but deliberately ignores a same-cycle pop, so the
  // FIFO can never be overrun by the response that lands one cycle later.
  assign w_credit   = r_count + CNT_W'(r_inflight);
  assign w_issue    = (r_state == StRun) && !redirect_valid && (w_credit < CNT_W'(DEPTH));
  assign w_push     = r_inflight && !redirect_valid;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && instr_ready;

  assign mem_chipselect = w_issue;
  assign mem_clken      = w_issue;
  assign mem_address    = w_issue ? r_pc : '0;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;

  assign instr_valid = w_nonempty;
  assign instr_data  = w_nonempty ? r_fifo_data[r_rptr] : '0;
  assign instr_pc    = w_nonempty ? r_fifo_pc[r_rptr] : '0;
  assign idle        = (r_state == StIdle) && !r_inflight && !w_nonempty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_pc       <= ADDR_W'(RESET_PC);
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      unique case (r_state)
        StIdle:  if (fetch_en)  r_state <= StRun;
        StRun:   if (!fetch_en) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      if (redirect_valid) begin
        // Flush: a pop reported this cycle is discarded along with the rest.
        r_pc       <= redirect_pc;
        r_inflight <= 1'b0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc  <= r_pc + ADDR_W'(1);
          r_tag <= r_pc;
        end
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // FIFO storage needs no reset; r_count qualifies every read.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_fifo_data[r_wptr] <= mem_readdata;
      r_fifo_pc[r_wptr]   <= r_tag;
    end
  end

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Self-checking bench for instr_fetch_prefetch with a 1-cycle-latency memory model
// holding mem[i] = 0xA000_0000 + i and a scoreboard of expected (pc, data) pops.
module tb_instr_fetch_prefetch;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fetch_en = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [31:0]       instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              idle;

  int n_tests = 0;
  int n_fail  = 0;
  int issues;
  logic [39:0] exp_q [$];

  instr_fetch_prefetch #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_clken     (mem_clken),
    .mem_write     (mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_readdata  (mem_readdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  // Memory: address registered on clken, data visible the next cycle.
  always @(posedge clk) begin
    if (mem_clken) mem_readdata <= 32'hA000_0000 + {24'h0, mem_address};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    logic [39:0] e;
    if (reset_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", {24'h0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", {24'h0, instr_pc}, {24'h0, e[39:32]});
        check("sb_data", instr_data, e[31:0]);
      end
    end
  end

  // FIFO occupancy must never exceed DEPTH.
  always @(negedge clk) begin
    if (reset_n) check("count_le_depth", {31'h0, dut.r_count <= DEPTH}, 32'd1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] pc, input logic [31:0] data);
    exp_q.push_back({pc, data});
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 8'(i);
      push_exp(pc, 32'hA000_0000 + {24'h0, pc});
    end
  endtask

  task automatic do_reset();
    cyc();
    reset_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_sb_empty(input string name);
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset values.
    do_reset();
    #1;
    check("rst_valid", {31'h0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", {24'h0, instr_pc}, 32'd0);
    check("rst_cs", {31'h0, mem_chipselect}, 32'd0);
    check("rst_clken", {31'h0, mem_clken}, 32'd0);
    check("rst_addr", {24'h0, mem_address}, 32'd0);
    check("rst_idle", {31'h0, idle}, 32'd1);
    check("rst_write", {31'h0, mem_write}, 32'd0);
    check("rst_be", {28'h0, mem_byteenable}, 32'hF);

    // 1: free-running stream from RESET_PC.
    push_seq(8'h00, 8);
    for (int c = 0; c < 12; c++) begin
      cyc();
      fetch_en = (c <= 10);
      instr_ready = (c <= 10);
      #1;
      if (c == 0) check("s1_c0_valid", {31'h0, instr_valid}, 32'd0);
      if (c == 1) begin
        check("s1_c1_cs", {31'h0, mem_chipselect}, 32'd1);
        check("s1_c1_addr", {24'h0, mem_address}, 32'd0);
      end
      if (c == 2) begin
        check("s1_c2_valid", {31'h0, instr_valid}, 32'd0);
        check("s1_c2_addr", {24'h0, mem_address}, 32'd1);
      end
      if (c == 3) begin
        check("s1_c3_valid", {31'h0, instr_valid}, 32'd1);
        check("s1_c3_pc", {24'h0, instr_pc}, 32'd0);
        check("s1_c3_data", instr_data, 32'hA000_0000);
      end
    end
    check_sb_empty("s1_sb_empty");

    // 2: consumer stalls, FIFO fills to DEPTH, then drains with no gap.
    do_reset();
    push_seq(8'h00, 10);
    issues = 0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      fetch_en = 1'b1;
      instr_ready = (c >= 11 && c <= 20);
      #1;
      if (c <= 10 && mem_chipselect) issues++;
      if (c == 10) begin
        check("s2_issues", issues, 32'd4);
        check("s2_cs_stalled", {31'h0, mem_chipselect}, 32'd0);
        check("s2_count", 32'(dut.r_count), 32'd4);
        check("s2_head_pc", {24'h0, instr_pc}, 32'd0);
      end
    end
    check_sb_empty("s2_sb_empty");

    // 3: redirect with 3 buffered entries and one read in flight.
    do_reset();
    push_seq(8'h40, 6);
    for (int c = 0; c < 15; c++) begin
      cyc();
      fetch_en = 1'b1;
      redirect_valid = (c == 5);
      redirect_pc = 8'h40;
      instr_ready = (c >= 8 && c <= 13);
      #1;
      if (c == 5) begin
        check("s3_pre_count", 32'(dut.r_count), 32'd3);
        check("s3_pre_inflight", {31'h0, dut.r_inflight}, 32'd1);
        check("s3_redir_cs", {31'h0, mem_chipselect}, 32'd0);
      end
      if (c == 6) begin
        check("s3_t1_valid", {31'h0, instr_valid}, 32'd0);
        check("s3_t1_addr", {24'h0, mem_address}, 32'h40);
      end
      if (c == 7) check("s3_t2_valid", {31'h0, instr_valid}, 32'd0);
      if (c == 8) begin
        check("s3_t3_valid", {31'h0, instr_valid}, 32'd1);
        check("s3_t3_pc", {24'h0, instr_pc}, 32'h40);
        check("s3_t3_data", instr_data, 32'hA000_0040);
      end
    end
    check_sb_empty("s3_sb_empty");

    // 4: redirect in IDLE to 0xFE, then PC wrap-around.
    do_reset();
    push_exp(8'hFE, 32'hA000_00FE);
    push_exp(8'hFF, 32'hA000_00FF);
    push_exp(8'h00, 32'hA000_0000);
    push_exp(8'h01, 32'hA000_0001);
    for (int c = 0; c < 9; c++) begin
      cyc();
      redirect_valid = (c == 0);
      redirect_pc = 8'hFE;
      fetch_en = (c >= 1);
      instr_ready = (c >= 4 && c <= 7);
      #1;
      if (c == 0) check("s4_idle_cs", {31'h0, mem_chipselect}, 32'd0);
      if (c == 2) check("s4_addr_fe", {24'h0, mem_address}, 32'hFE);
      if (c == 4) check("s4_head_pc", {24'h0, instr_pc}, 32'hFE);
    end
    check_sb_empty("s4_sb_empty");

    // 5: fetch_en dropped mid-stream, drain to idle, resume sequentially.
    do_reset();
    push_seq(8'h00, 9);
    for (int c = 0; c < 18; c++) begin
      cyc();
      fetch_en = (c < 5) || (c >= 10);
      instr_ready = (c >= 3 && c <= 7) || (c >= 13 && c <= 16);
      #1;
      if (c == 5) check("s5_last_issue", {24'h0, mem_address}, 32'd4);
      if (c == 6) check("s5_no_issue", {31'h0, mem_chipselect}, 32'd0);
      if (c == 7) check("s5_not_idle", {31'h0, idle}, 32'd0);
      if (c == 8) begin
        check("s5_idle", {31'h0, idle}, 32'd1);
        check("s5_empty", {31'h0, instr_valid}, 32'd0);
      end
      if (c == 9) check("s5_idle_cs", {31'h0, mem_chipselect}, 32'd0);
      if (c == 11) begin
        check("s5_resume_cs", {31'h0, mem_chipselect}, 32'd1);
        check("s5_resume_addr", {24'h0, mem_address}, 32'd5);
      end
    end
    check_sb_empty("s5_sb_empty");

    // 6: reset mid-stream together with a redirect; the redirect is ignored.
    do_reset();
    push_seq(8'h00, 3);
    push_seq(8'h00, 2);
    for (int c = 0; c < 13; c++) begin
      cyc();
      reset_n = (c != 6);
      redirect_valid = (c == 6);
      redirect_pc = 8'h80;
      fetch_en = 1'b1;
      instr_ready = (c >= 3 && c <= 5) || (c >= 10 && c <= 11);
      #1;
      if (c == 7) begin
        check("s6_valid", {31'h0, instr_valid}, 32'd0);
        check("s6_data", instr_data, 32'd0);
        check("s6_pc", {24'h0, instr_pc}, 32'd0);
        check("s6_cs", {31'h0, mem_chipselect}, 32'd0);
        check("s6_addr", {24'h0, mem_address}, 32'd0);
        check("s6_idle", {31'h0, idle}, 32'd1);
        check("s6_rpc", {24'h0, dut.r_pc}, 32'd0);
      end
      if (c == 8) begin
        check("s6_restart_cs", {31'h0, mem_chipselect}, 32'd1);
        check("s6_restart_addr", {24'h0, mem_address}, 32'd0);
      end
    end
    check_sb_empty("s6_sb_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
